// File: rtl/alu_seq_unit_if.sv
// Handshake and data bundle between the operand source, the sequential ALU and writeback.
interface alu_seq_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             sign;
   logic             err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero, sign, err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero, sign, err
   );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, 1-bit-per-cycle shifter and
// shift-add multiplier, with valid/ready handshakes on both sides.
module alu_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_unit_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_XOR = 5'b00100;
   localparam logic [4:0] OP_NOT = 5'b00101;
   localparam logic [4:0] OP_SLL = 5'b00110;
   localparam logic [4:0] OP_SRL = 5'b00111;
   localparam logic [4:0] OP_SRA = 5'b01000;
   localparam logic [4:0] OP_MUL = 5'b01001;

   typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [4:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic               err_q;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   imm_result;
   logic               imm_carry;
   logic               imm_err;
   logic               accept;
   logic               is_shift;
   logic [SHW-1:0]     shamt;

   assign accept   = bus.in_valid && (state == IDLE);
   assign shamt    = bus.b[SHW-1:0];
   assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);

   // Upper accumulator half absorbs the multiplicand while the multiplier drains out of the low half.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
   assign acc_next = {mul_sum, acc[WIDTH-1:1]};

   always_comb begin
      imm_result = '0;
      imm_carry  = 1'b0;
      imm_err    = 1'b0;
      sum        = '0;
      case (bus.op)
         OP_ADD: begin
            sum        = {1'b0, bus.a} + {1'b0, bus.b};
            imm_result = sum[WIDTH-1:0];
            imm_carry  = sum[WIDTH];
         end
         OP_SUB: begin
            sum        = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
            imm_result = sum[WIDTH-1:0];
            imm_carry  = sum[WIDTH];
         end
         OP_AND:                 imm_result = bus.a & bus.b;
         OP_OR:                  imm_result = bus.a | bus.b;
         OP_XOR:                 imm_result = bus.a ^ bus.b;
         OP_NOT:                 imm_result = ~bus.a;
         OP_SLL, OP_SRL, OP_SRA: imm_result = bus.a;
         OP_MUL:                 imm_result = '0;
         default:                imm_err    = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) state_next = SHIFT;
               else if (bus.op == OP_MUL)     state_next = MUL;
               else                           state_next = DONE;
            end
         end
         SHIFT:   if (cnt == '0) state_next = DONE;
         MUL:     if (cnt == '0) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // result_q doubles as the shift register so the final shifted value needs no extra copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= bus.op;
                  a_q      <= bus.a;
                  result_q <= imm_result;
                  carry_q  <= imm_carry;
                  err_q    <= imm_err;
                  cnt      <= (bus.op == OP_MUL) ? {SHW{1'b1}} : shamt - SHW'(1);
                  acc      <= {{WIDTH{1'b0}}, bus.b};
               end
            end
            SHIFT: begin
               cnt <= cnt - SHW'(1);
               case (op_q)
                  OP_SLL: begin
                     result_q <= {result_q[WIDTH-2:0], 1'b0};
                     carry_q  <= result_q[WIDTH-1];
                  end
                  OP_SRL: begin
                     result_q <= {1'b0, result_q[WIDTH-1:1]};
                     carry_q  <= result_q[0];
                  end
                  default: begin
                     result_q <= {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                     carry_q  <= result_q[0];
                  end
               endcase
            end
            MUL: begin
               acc <= acc_next;
               cnt <= cnt - SHW'(1);
               if (cnt == '0) begin
                  result_q <= acc_next[WIDTH-1:0];
                  carry_q  <= |acc_next[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = bus.out_valid && (result_q == '0);
   assign bus.sign      = result_q[WIDTH-1];
   assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised and directed bench for alu_seq_unit (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq_unit;
   logic clk;
   logic rst;
   int   checkCount;
   int   errorCount;

   alu_seq_unit_if #(.WIDTH(32)) bus ();

   alu_seq_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain wide arithmetic straight from the opcode definitions.
   function automatic void refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic c, output logic e,
                                    output int lat);
      logic [63:0] wide;
      int sh;
      sh  = int'(b[4:0]);
      res = '0;
      c   = 1'b0;
      e   = 1'b0;
      lat = 1;
      case (op)
         5'd0: begin wide = 64'(a) + 64'(b); res = wide[31:0]; c = (wide > 64'hFFFF_FFFF); end
         5'd1: begin res = a - b; c = (a >= b); end
         5'd2: res = a & b;
         5'd3: res = a | b;
         5'd4: res = a ^ b;
         5'd5: res = ~a;
         5'd6: begin
            wide = 64'(a) << sh; res = wide[31:0]; c = (sh != 0) ? wide[32] : 1'b0;
            lat = (sh == 0) ? 1 : sh + 1;
         end
         5'd7: begin
            wide = {a, 32'h0} >> sh; res = wide[63:32]; c = (sh != 0) ? wide[31] : 1'b0;
            lat = (sh == 0) ? 1 : sh + 1;
         end
         5'd8: begin
            wide = 64'($signed({a, 32'h0}) >>> sh); res = wide[63:32]; c = (sh != 0) ? wide[31] : 1'b0;
            lat = (sh == 0) ? 1 : sh + 1;
         end
         5'd9: begin wide = 64'(a) * 64'(b); res = wide[31:0]; c = (wide[63:32] != 0); lat = 33; end
         default: e = 1'b1;
      endcase
   endfunction

   // Presents one operation, waits for the result, optionally holds off out_ready, then retires it.
   task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
      logic [31:0] expRes;
      logic        expC;
      logic        expE;
      int          expLat;
      int          lat;
      refModel(op, a, b, expRes, expC, expE, expLat);
      @(negedge clk);
      checkOutput({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.op = 5'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, ".result"}, 64'(bus.result), 64'(expRes));
      checkOutput({tag, ".carry"}, 64'(bus.carry), 64'(expC));
      checkOutput({tag, ".zero"}, 64'(bus.zero), 64'(expRes == 0));
      checkOutput({tag, ".sign"}, 64'(bus.sign), 64'(expRes[31]));
      checkOutput({tag, ".err"}, 64'(bus.err), 64'(expE));
      checkOutput({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
         checkOutput({tag, ".hold_result"}, 64'(bus.result), 64'(expRes));
         checkOutput({tag, ".hold_flags"}, {60'd0, bus.carry, bus.zero, bus.sign, bus.err},
                     {60'd0, expC, expRes == 0, expRes[31], expE});
         checkOutput({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, ".retire_valid"}, 64'(bus.out_valid), 64'd0);
      checkOutput({tag, ".retire_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [4:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      checkCount = 0;
      errorCount = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op = '0;
      #12;
      checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset.result", 64'(bus.result), 64'd0);
      checkOutput("reset.flags", {60'd0, bus.carry, bus.zero, bus.sign, bus.err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);

      applyStimulus("add_15_10", 5'd0, 32'd15, 32'd10, 0);
      applyStimulus("sub_10_15", 5'd1, 32'd10, 32'd15, 0);
      applyStimulus("sub_15_15", 5'd1, 32'd15, 32'd15, 0);
      applyStimulus("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
      applyStimulus("sra_4", 5'd8, 32'h8000_0001, 32'd4, 0);
      applyStimulus("sll_1", 5'd6, 32'h8000_0000, 32'd1, 0);
      applyStimulus("srl_0", 5'd7, 32'hDEAD_BEEF, 32'd0, 0);
      applyStimulus("srl_31", 5'd7, 32'hC000_0000, 32'd31, 0);
      applyStimulus("mul_15_10", 5'd9, 32'd15, 32'd10, 0);
      applyStimulus("mul_ovf", 5'd9, 32'h0001_0000, 32'h0001_0000, 0);
      applyStimulus("add_backpressure", 5'd0, 32'h7FFF_FFFF, 32'd3, 3);
      applyStimulus("illegal_31", 5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      applyStimulus("after_illegal", 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

      // Reset in the middle of a multiply must discard it without ever raising out_valid.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 5'd9;
      bus.a = 32'd1234;
      bus.b = 32'd5678;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midmul.out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("midmul.result", 64'(bus.result), 64'd0);
      checkOutput("midmul.flags", {60'd0, bus.carry, bus.zero, bus.sign, bus.err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("midmul.no_stale", 64'(bus.out_valid), 64'd0);
      applyStimulus("post_reset_add", 5'd0, 32'd1, 32'd1, 0);

      for (int n = 0; n < 60; n++) begin
         rop = 5'($urandom_range(0, 11));
         if (rop > 5'd9) rop = 5'($urandom_range(10, 31));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
         applyStimulus($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, multi-cycle successor to the team's combinational 32-bit ALU.
- Adds WIDTH generalisation, valid/ready handshakes on input and output, an iterative shifter (1 bit/cycle) and an iterative shift-add multiplier.
- Sits between register-file read and writeback in the multi-cycle datapath.
- Flags carry/zero/sign are retained and extended with an illegal-op error flag.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of 2).
- SHW, $clog2(WIDTH), derived; shift-amount width taken from b[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount (low SHW bits)
- op  in  5  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- carry  out  1  carry/borrow/shift-out/overflow flag
- zero  out  1  result == 0
- sign  out  1  result[WIDTH-1]
- err  out  1  illegal opcode

Behaviour:
- Opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 NOT(a), 00110 SLL, 00111 SRL, 01000 SRA, 01001 MUL (unsigned, low WIDTH bits). All other codes are illegal.
- States: IDLE, SHIFT, MUL, DONE.
- Accept: in_valid && in_ready on a rising edge; a, b and op are registered at that edge, so inputs may change afterwards.
- IDLE → DONE on the accept edge for ADD/SUB/logic/illegal ops, and for shifts with shamt=0. out_valid rises 1 cycle after accept.
- IDLE → SHIFT for shifts with shamt≠0. One bit is shifted per cycle; after shamt cycles go to DONE. out_valid rises shamt+1 cycles after accept.
- IDLE → MUL for MUL. Shift-add runs for WIDTH cycles into a 2·WIDTH accumulator, then goes to DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE: result and flags are held stable while out_ready=0. On out_valid && out_ready, go to IDLE next cycle. No same-cycle re-accept, so in_ready=0 in DONE.
- Arithmetic:
  - ADD: {carry,result} = a+b.
  - SUB: {carry,result} = a+~b+1, so carry=1 means no borrow (a ≥ b unsigned).
- carry for logic ops: 0.
- carry for shifts: last bit shifted out; 0 if shamt=0.
- carry for MUL: 1 iff product[2·WIDTH-1:WIDTH] ≠ 0.
- SRA replicates a[WIDTH-1]; SLL/SRL fill with 0.
- zero = (result==0) and sign = result[WIDTH-1], both evaluated on the final result and valid only with out_valid.
- Illegal op: result=0, carry=0, zero=1, sign=0, err=1, 1-cycle latency. err=0 for all legal ops.
- Reset: asynchronous on rst high.
  - State → IDLE.
  - in_ready=1 after deassertion.
  - out_valid, result, carry, zero, sign, err all 0.
  - Any in-flight shift/MUL is discarded, and no result is produced for it.
- in_valid while busy is ignored (in_ready=0); no queueing.
- result/flags outside out_valid are don't-care for the bench, but they must not change while out_valid=1.

Test Plan (WIDTH=32):
- ADD a=15, b=10, out_ready=1 → out_valid 1 cycle after accept; result=25, carry=0, zero=0, sign=0. SUB a=10, b=15 → result=0xFFFFFFFB, carry=0, sign=1. SUB a=15, b=15 → result=0, zero=1, carry=1.
- SRA a=0x80000001, b=4 → out_valid 5 cycles after accept; result=0xF8000000, carry=0. SLL a=0x80000000, b=1 → result=0, carry=1, zero=1. SRL b=0 → result=a, 1-cycle latency.
- MUL a=15, b=10 → out_valid 33 cycles after accept; result=150, carry=0. MUL a=0x10000, b=0x10000 → result=0, carry=1, zero=1.
- Backpressure: ADD completes with out_ready=0 for 3 cycles → out_valid, result and flags stable, in_ready=0. out_ready=1 → IDLE and in_ready=1 next cycle.
- Reset mid-MUL: assert rst 10 cycles after accept, asynchronously between edges → out_valid=0 and outputs 0 immediately. After release, ADD 1+1 → result=2 with normal latency, no stale MUL result.
- Illegal op=11111 → err=1, result=0, zero=1, 1-cycle latency. The next legal op returns err=0.
